control_unit_pipe: RTL
======================

# control_unit_pipe

Second-generation control unit for the pipelined RV32 core: combinational decode of `Op`/`funct3`/`funct7` in the Decode stage, plus a registered ID/EX control bundle with stall, flush and multi-cycle M-extension sequencing. It widens ALU and immediate encodings to the full RV32I base, adds AUIPC, illegal-instruction flagging and an optional fixed-latency mul/div occupancy FSM. It sits between the instruction register and the Execute stage and feeds the hazard unit.

## Interface
- `ALU_CTRL_W`, 4: ALUControl width; minimum 4.
- `ENABLE_M`, 1: 1 decodes RV32M; 0 flags M ops illegal.
- `MULDIV_LATENCY`, 4: cycles an M op occupies Execute; minimum 1.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `Op` in 7, `funct3` in 3, `funct7` in 7: Decode-stage instruction fields.
- `StallD` in 1: hold the E register (hazard unit stall).
- `FlushE` in 1: load a bubble into the E register.
- `ImmSrcD` out 3: combinational; 000 I, 001 S, 010 B, 011 J, 100 U.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `ALUSrcE` out 1 each: registered.
- `ALUSrcAE` out 1: registered; 0 rs1, 1 PC (AUIPC).
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+4, 11 mul/div result.
- `ALUControlE` out `ALU_CTRL_W`: registered.
- `MulDivE` out 1: E holds an M op.
- `MulDivBusy` out 1: E occupied by an unfinished M op; hazard unit stalls F/D.
- `MulDivDone` out 1: final cycle of the M op in E.
- `IllegalE` out 1: E holds an illegal instruction (already a bubble).

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB (LUI); upper bits zero.
- Opcodes: load, store, R, I-ALU, branch, JAL, JALR, LUI, AUIPC. SUB only for R-type with `funct7[5]`=1; SRA when `funct7[5]`=1 in R- or I-type shift. Branch uses SUB (BEQ/BNE/BLT/BGE) or SLTU (BLTU/BGEU).
- M op: `Op`=0110011, `funct7`=0000001. `ResultSrc`=11, `RegWrite`=1, `MulDivE`=1.
- Illegal: unknown opcode, reserved `funct7` for R/shift, or M op with `ENABLE_M`=0. Captured as a bubble with `IllegalE`=1.
- Bubble: every E control 0, `ALUControlE`=0, `IllegalE`=0 unless illegal.
- E register update priority: reset > hold (`MulDivBusy` or `StallD`) > `FlushE` (bubble) > capture of decode.
- FSM IDLE/BUSY, counter width $clog2(MULDIV_LATENCY).
  - Capture of M op: counter loads `MULDIV_LATENCY`-1. BUSY if nonzero, else stays IDLE with `MulDivDone`=1.
  - BUSY, cnt≠0: `MulDivBusy`=1, decrement.
  - BUSY, cnt=0: `MulDivDone`=1, `MulDivBusy`=0, E accepts next. Back-to-back M op reloads and stays BUSY; otherwise IDLE.
- `FlushE` while `MulDivBusy`=1 is ignored; the M op completes.

## Timing
- `ImmSrcD`: zero latency. E outputs: one cycle after capture.
- M op occupies E exactly `MULDIV_LATENCY` cycles: `MulDivBusy` high for the first L-1, `MulDivDone` high for the last.
- Reset, including mid-M-op: all E outputs, `MulDivBusy` and `MulDivDone` 0; FSM IDLE; counter 0. Takes effect immediately, asynchronously.

## Structure
- `riscv_pkg`: opcode constants, ALU codes, ImmSrc and ResultSrc encodings, `ctrl_t` struct for the E bundle.
- Sub-module `control_decode`: pure combinational decode producing `ctrl_t` and `ImmSrcD`. The top holds the E register, FSM and counter.

## Test plan
- ADD then SUB R-type (`funct7` 0x00/0x20) -> next cycle `ALUControlE`=0 then 1, `RegWriteE`=1, `ResultSrcE`=00.
- AUIPC -> `ImmSrcD`=100, `ALUSrcAE`=1, `ALUSrcE`=1, `ALUControlE`=0. LUI -> `ALUControlE`=10.
- MUL with L=4 -> `MulDivBusy` 1,1,1,0 and `MulDivDone` 0,0,0,1; `FlushE` pulse mid-busy ignored. Back-to-back MUL gives 8 cycles of occupancy.
- Opcode 0x7F, and MUL with `ENABLE_M`=0 -> `IllegalE`=1, `RegWriteE`=`MemWriteE`=0.
- `StallD` held 2 cycles with LW -> E holds LW bundle. `FlushE` -> all-zero bubble next cycle.
- `rst` low during BUSY cnt=2 -> outputs 0 immediately; after release a new MUL runs full L cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32 control path: opcodes, ALU codes,
// immediate/result selects, the E-stage control bundle and the M-op FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_PC4    = 2'b10;
  localparam logic [1:0] RES_MULDIV = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       alu_src_a;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
    logic       muldiv;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // Register-register / register-immediate ALU op; alt selects SUB/SRA.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational Decode-stage control: maps Op/funct3/funct7 to the E bundle
// and the immediate format select. Illegal encodings collapse to a flagged bubble.
module control_decode
  import riscv_pkg::*;
#(
  parameter int ENABLE_M = 1
) (
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic [2:0] imm_src_o
);

  ctrl_t      ctrl;
  logic [2:0] imm_src;
  logic       illegal;

  // Opcode decode; any illegal case overrides the bundle with a bubble.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (op_i)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        imm_src        = IMM_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALU;
        if (funct7_i == F7_BASE) begin
          ctrl.alu_ctrl = alu_from_funct3(funct3_i, 1'b0);
        end else if (funct7_i == F7_ALT && (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
          ctrl.alu_ctrl = alu_from_funct3(funct3_i, 1'b1);
        end else if (funct7_i == F7_MULDIV && ENABLE_M != 0) begin
          ctrl.muldiv     = 1'b1;
          ctrl.result_src = RES_MULDIV;
          ctrl.alu_ctrl   = ALU_ADD;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // Only the shift-immediates carry a funct7 field.
        if (funct3_i == 3'b001) begin
          ctrl.alu_ctrl = ALU_SLL;
          illegal       = (funct7_i != F7_BASE);
        end else if (funct3_i == 3'b101) begin
          ctrl.alu_ctrl = funct7_i[5] ? ALU_SRA : ALU_SRL;
          illegal       = (funct7_i != F7_BASE) && (funct7_i != F7_ALT);
        end else begin
          ctrl.alu_ctrl = alu_from_funct3(funct3_i, 1'b0);
        end
      end
      OP_BRANCH: begin
        imm_src       = IMM_B;
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = (funct3_i[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
      end
      OP_JAL: begin
        imm_src         = IMM_J;
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_LUI: begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        imm_src        = IMM_U;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl         = CTRL_BUBBLE;
      ctrl.illegal = 1'b1;
    end
  end

  assign ctrl_o    = ctrl;
  assign imm_src_o = imm_src;

endmodule

// File: rtl/control_unit_pipe.sv
// RV32 pipelined control unit: Decode-stage decode plus the ID/EX control
// register with stall/flush and fixed-latency mul/div occupancy tracking.
//
// state   | meaning
// --------+--------------------------------------------------------------
// MD_IDLE | E holds no unfinished M op; E register free to advance
// MD_BUSY | E holds an M op; cnt counts remaining cycles, 0 = final cycle
module control_unit_pipe
  import riscv_pkg::*;
#(
  parameter int ALU_CTRL_W     = 4,
  parameter int ENABLE_M       = 1,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            Op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  StallD,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  ALUSrcE,
  output logic                  ALUSrcAE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  MulDivE,
  output logic                  MulDivBusy,
  output logic                  MulDivDone,
  output logic                  IllegalE
);

  // A latency of 1 still needs a one-bit counter to keep the vector legal.
  localparam int CNT_W = (MULDIV_LATENCY > 1) ? $clog2(MULDIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LATENCY - 1);

  ctrl_t             ctrl_dec;
  ctrl_t             e_q, e_d;
  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  control_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .op_i      (Op),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .ctrl_o    (ctrl_dec),
    .imm_src_o (ImmSrcD)
  );

  // Next E bundle and M-op sequencing: hold > flush > capture.
  always_comb begin
    e_d     = e_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (busy_q) begin
      // Flush is ignored here: the M op must finish its occupancy.
      cnt_d  = cnt_q - CNT_W'(1);
      busy_d = (cnt_q != CNT_W'(1));
      done_d = (cnt_q == CNT_W'(1));
    end else if (StallD) begin
      e_d = e_q;
    end else if (FlushE) begin
      e_d     = CTRL_BUBBLE;
      state_d = MD_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      e_d = ctrl_dec;
      if (ctrl_dec.muldiv) begin
        cnt_d   = CNT_LOAD;
        state_d = (CNT_LOAD != '0) ? MD_BUSY : MD_IDLE;
        busy_d  = (CNT_LOAD != '0);
        done_d  = (CNT_LOAD == '0);
      end else begin
        state_d = MD_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    end
  end

  // E register, FSM state, counter and registered busy/done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q     <= CTRL_BUBBLE;
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      e_q     <= e_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign BranchE     = e_q.branch;
  assign JumpE       = e_q.jump;
  assign ALUSrcE     = e_q.alu_src;
  assign ALUSrcAE    = e_q.alu_src_a;
  assign ResultSrcE  = e_q.result_src;
  assign ALUControlE = ALU_CTRL_W'(e_q.alu_ctrl);
  assign MulDivE     = e_q.muldiv;
  assign IllegalE    = e_q.illegal;
  assign MulDivBusy  = busy_q;
  assign MulDivDone  = done_q;

endmodule
